// File: rtl/pxs_pkg.sv
// Shared definitions for the ball-motion sequencer: pixel-stream field
// positions, FSM state type and the coordinate type.
package pxs_pkg;

  // Bit positions inside the 26-bit pixel stream word
  localparam int PX_ACTIVE  = 0;
  localparam int PX_VS      = 1;
  localparam int PX_HS      = 2;
  localparam int PX_YC_LSB  = 3;
  localparam int PX_YC_MSB  = 12;
  localparam int PX_XC_LSB  = 13;
  localparam int PX_XC_MSB  = 22;
  localparam int PX_RGB_LSB = 23;
  localparam int PX_RGB_MSB = 25;

  typedef logic [9:0] coord_t;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_EOF = 3'd1,
    ST_UPD_X    = 3'd2,
    ST_UPD_Y    = 3'd3,
    ST_COMMIT   = 3'd4
  } state_e;

endpackage

// File: rtl/pxs_axis_step.sv
// One-axis motion step: advance position p by s in direction d, reflecting
// at [p_min, p_max]. Arithmetic is done 11 bits wide so p+s never wraps.
module pxs_axis_step
  import pxs_pkg::*;
(
  input  logic [9:0] p,
  input  logic       d,
  input  logic [4:0] s,
  input  logic [9:0] p_min,
  input  logic [9:0] p_max,
  output logic [9:0] p_nxt,
  output logic       d_nxt,
  output logic       bounce
);

  logic [10:0] p_ext, s_ext, sum, diff, lo_thr;

  // Step/reflect; zero speed is a pure hold so a ball parked on a limit
  // does not keep reporting bounces.
  always_comb begin
    p_ext  = {1'b0, p};
    s_ext  = {6'd0, s};
    sum    = p_ext + s_ext;
    diff   = p_ext - s_ext;
    lo_thr = {1'b0, p_min} + s_ext;
    p_nxt  = p;
    d_nxt  = d;
    bounce = 1'b0;
    if (s != 5'd0) begin
      if (!d) begin
        if (sum >= {1'b0, p_max}) begin
          p_nxt  = p_max;
          d_nxt  = 1'b1;
          bounce = 1'b1;
        end else begin
          p_nxt = sum[9:0];
        end
      end else begin
        if (p_ext < lo_thr) begin
          p_nxt  = p_min;
          d_nxt  = 1'b0;
          bounce = 1'b1;
        end else begin
          p_nxt = diff[9:0];
        end
      end
    end
  end

endmodule

// File: rtl/pxs_ball_motion_ctrl.sv
// Per-frame bouncing-logo sequencer. Waits for the last visible pixel,
// steps X then Y through one shared axis unit, and commits both axes and
// any pending speed change together so the overlay sees a stable frame.
module pxs_ball_motion_ctrl
  import pxs_pkg::*;
#(
  parameter int VISIBLECOLS = 640,
  parameter int VISIBLEROWS = 480,
  parameter int WIDTH_LOGO  = 80,
  parameter int HEIGHT_LOGO = 96,
  parameter int BORDER      = 0,
  parameter int MAX_SPEED   = 20,
  parameter int INIT_SPEED  = 1
) (
  input  logic        px_clk,
  input  logic        rst_n,
  input  logic [25:0] RGBStr_i,
  input  logic        launch,
  input  logic        pause,
  input  logic        inc_vel,
  input  logic        dec_vel,
  output logic [9:0]  x_logo,
  output logic [9:0]  y_logo,
  output logic [4:0]  speed,
  output logic        dx,
  output logic        dy,
  output logic        bounce_x,
  output logic        bounce_y,
  output logic        running
);

  localparam coord_t     X_MIN   = coord_t'(BORDER);
  localparam coord_t     X_MAX   = coord_t'(VISIBLECOLS - WIDTH_LOGO - BORDER);
  localparam coord_t     Y_MIN   = coord_t'(BORDER);
  localparam coord_t     Y_MAX   = coord_t'(VISIBLEROWS - HEIGHT_LOGO - BORDER);
  localparam coord_t     X_RST   = coord_t'((VISIBLECOLS - WIDTH_LOGO) / 4);
  localparam coord_t     Y_RST   = coord_t'((VISIBLEROWS - HEIGHT_LOGO) / 2);
  localparam coord_t     XC_LAST = coord_t'(VISIBLECOLS - 1);
  localparam coord_t     YC_LAST = coord_t'(VISIBLEROWS - 1);
  localparam logic [4:0] SPD_MAX = 5'(MAX_SPEED);
  localparam logic [4:0] SPD_RST = 5'(INIT_SPEED);

  state_e state, state_nxt;
  coord_t xc, yc;
  logic   eof;
  logic   unused_px;

  coord_t st_p, st_p_nxt, st_min, st_max;
  logic   st_d, st_d_nxt, st_bounce, upd_y;

  coord_t x_sh, y_sh;
  logic   dx_sh, dy_sh, bx_sh;
  logic   inc_pend, dec_pend;

  assign xc  = RGBStr_i[PX_XC_MSB:PX_XC_LSB];
  assign yc  = RGBStr_i[PX_YC_MSB:PX_YC_LSB];
  assign eof = (xc == XC_LAST) && (yc == YC_LAST);

  // Colour and sync bits are carried on the tap but play no part here
  assign unused_px = ^{RGBStr_i[PX_RGB_MSB:PX_RGB_LSB], RGBStr_i[PX_HS],
                       RGBStr_i[PX_VS], RGBStr_i[PX_ACTIVE]};

  assign running = (state != ST_IDLE);

  // Next-state: wait for an unpaused eof, then three fixed update cycles
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:     if (launch) state_nxt = ST_WAIT_EOF;
      ST_WAIT_EOF: if (eof && !pause) state_nxt = ST_UPD_X;
      ST_UPD_X:    state_nxt = ST_UPD_Y;
      ST_UPD_Y:    state_nxt = ST_COMMIT;
      ST_COMMIT:   state_nxt = ST_WAIT_EOF;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge px_clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Shared step unit sees Y during UPD_Y and X otherwise; the committed
  // position is still the pre-step one while either axis is being stepped.
  assign upd_y  = (state == ST_UPD_Y);
  assign st_p   = upd_y ? y_logo : x_logo;
  assign st_d   = upd_y ? dy     : dx;
  assign st_min = upd_y ? Y_MIN  : X_MIN;
  assign st_max = upd_y ? Y_MAX  : X_MAX;

  pxs_axis_step u_step (
    .p      (st_p),
    .d      (st_d),
    .s      (speed),
    .p_min  (st_min),
    .p_max  (st_max),
    .p_nxt  (st_p_nxt),
    .d_nxt  (st_d_nxt),
    .bounce (st_bounce)
  );

  // Capture per-axis step results until both are ready
  always_ff @(posedge px_clk or negedge rst_n) begin
    if (!rst_n) begin
      x_sh  <= X_RST;
      y_sh  <= Y_RST;
      dx_sh <= 1'b0;
      dy_sh <= 1'b0;
      bx_sh <= 1'b0;
    end else begin
      if (state == ST_UPD_X) begin
        x_sh  <= st_p_nxt;
        dx_sh <= st_d_nxt;
        bx_sh <= st_bounce;
      end
      if (state == ST_UPD_Y) begin
        y_sh  <= st_p_nxt;
        dy_sh <= st_d_nxt;
      end
    end
  end

  // Bounce flags are registered out of UPD_Y so they are high exactly in COMMIT
  always_ff @(posedge px_clk or negedge rst_n) begin
    if (!rst_n) begin
      bounce_x <= 1'b0;
      bounce_y <= 1'b0;
    end else begin
      bounce_x <= upd_y && bx_sh;
      bounce_y <= upd_y && st_bounce;
    end
  end

  // Publish both axes at once in COMMIT
  always_ff @(posedge px_clk or negedge rst_n) begin
    if (!rst_n) begin
      x_logo <= X_RST;
      y_logo <= Y_RST;
      dx     <= 1'b0;
      dy     <= 1'b0;
    end else if (state == ST_COMMIT) begin
      x_logo <= x_sh;
      y_logo <= y_sh;
      dx     <= dx_sh;
      dy     <= dy_sh;
    end
  end

  // Sticky speed requests; COMMIT applies one step and keeps any pulse
  // that lands in the COMMIT cycle itself for the next frame.
  always_ff @(posedge px_clk or negedge rst_n) begin
    if (!rst_n) begin
      speed    <= SPD_RST;
      inc_pend <= 1'b0;
      dec_pend <= 1'b0;
    end else if (state == ST_COMMIT) begin
      if (inc_pend && !dec_pend && speed != SPD_MAX) speed <= speed + 5'd1;
      if (dec_pend && !inc_pend && speed != 5'd0)    speed <= speed - 5'd1;
      inc_pend <= inc_vel;
      dec_pend <= dec_vel;
    end else begin
      inc_pend <= inc_pend | inc_vel;
      dec_pend <= dec_pend | dec_vel;
    end
  end

endmodule

// File: tb/tb_pxs_ball_motion_ctrl.sv
// Randomized frame-level bench for pxs_ball_motion_ctrl. A per-frame model
// of the motion rules predicts every output on every cycle.
module tb_pxs_ball_motion_ctrl;

  localparam int X_MAX = 560;
  localparam int Y_MAX = 384;

  logic        px_clk = 1'b0;
  logic        rst_n;
  logic [25:0] RGBStr_i;
  logic        launch, pause, inc_vel, dec_vel;
  logic [9:0]  x_logo, y_logo;
  logic [4:0]  speed;
  logic        dx, dy, bounce_x, bounce_y, running;

  pxs_ball_motion_ctrl dut (
    .px_clk   (px_clk),
    .rst_n    (rst_n),
    .RGBStr_i (RGBStr_i),
    .launch   (launch),
    .pause    (pause),
    .inc_vel  (inc_vel),
    .dec_vel  (dec_vel),
    .x_logo   (x_logo),
    .y_logo   (y_logo),
    .speed    (speed),
    .dx       (dx),
    .dy       (dy),
    .bounce_x (bounce_x),
    .bounce_y (bounce_y),
    .running  (running)
  );

  always #5 px_clk = ~px_clk;

  int n_vec = 0;
  int n_err = 0;

  // model state
  int m_x, m_y, m_dx, m_dy, m_sp, e_bx, e_by;
  bit m_run, m_inc, m_dec;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_x = 140; m_y = 192; m_dx = 0; m_dy = 0; m_sp = 1;
    e_bx = 0; e_by = 0; m_run = 0; m_inc = 0; m_dec = 0;
  endfunction

  // Motion rule for one axis over the range [lo, hi]
  function automatic void axis(input int p, input int d, input int s, input int lo,
                               input int hi, output int np, output int nd, output int nb);
    np = p; nd = d; nb = 0;
    if (s == 0) return;
    if (d == 0) begin
      if (p + s >= hi) begin np = hi; nd = 1; nb = 1; end
      else np = p + s;
    end else begin
      if (p < lo + s) begin np = lo; nd = 0; nb = 1; end
      else np = p - s;
    end
  endfunction

  task automatic check_all(input string ph);
    chk({ph, ".x"},   32'(x_logo),   32'(m_x));
    chk({ph, ".y"},   32'(y_logo),   32'(m_y));
    chk({ph, ".spd"}, 32'(speed),    32'(m_sp));
    chk({ph, ".dx"},  32'(dx),       32'(m_dx));
    chk({ph, ".dy"},  32'(dy),       32'(m_dy));
    chk({ph, ".bx"},  32'(bounce_x), 32'(e_bx));
    chk({ph, ".by"},  32'(bounce_y), 32'(e_by));
    chk({ph, ".run"}, 32'(running),  32'(m_run));
  endtask

  // Random pixel that is never the last visible one
  task automatic drive_noise();
    RGBStr_i = {3'($urandom), 10'($urandom_range(0, 639)),
                10'($urandom_range(0, 478)), 3'($urandom)};
  endtask

  task automatic drive_quiet();
    launch = 0; inc_vel = 0; dec_vel = 0; pause = 0;
  endtask

  task automatic drive_pulses(input int pl, input int pi, input int pd, input int pp);
    launch  = ($urandom_range(0, 99) < pl);
    inc_vel = ($urandom_range(0, 99) < pi);
    dec_vel = ($urandom_range(0, 99) < pd);
    pause   = ($urandom_range(0, 99) < pp);
  endtask

  // Fold the just-driven request pulses into the model (outside COMMIT)
  task automatic absorb();
    if (inc_vel) m_inc = 1;
    if (dec_vel) m_dec = 1;
    if (launch)  m_run = 1;
  endtask

  // One frame: idle gap with random requests, one eof, then the 4 cycles
  // of update latency. Optionally reset while the Y step is in flight.
  task automatic frame(input int pl, input int pi, input int pd, input int pp,
                       input bit rst_updy);
    int gaps, nx, ny, ndx, ndy, bx, by, ns;
    bit upd, in_rst;
    gaps = $urandom_range(1, 6);
    in_rst = 0;
    ns = m_sp;
    nx = m_x; ny = m_y; ndx = m_dx; ndy = m_dy; bx = 0; by = 0;
    for (int g = 0; g < gaps; g++) begin
      @(negedge px_clk);
      check_all("gap");
      drive_noise();
      drive_pulses(pl, pi, pd, pp);
      absorb();
    end
    @(negedge px_clk);
    check_all("eof");
    RGBStr_i = {3'($urandom), 10'd639, 10'd479, 3'($urandom)};
    drive_quiet();
    pause = ($urandom_range(0, 99) < pp);
    upd = m_run && !pause;
    if (upd) begin
      axis(m_x, m_dx, m_sp, 0, X_MAX, nx, ndx, bx);
      axis(m_y, m_dy, m_sp, 0, Y_MAX, ny, ndy, by);
    end
    for (int k = 1; k <= 4; k++) begin
      @(negedge px_clk);
      if (k == 3 && upd) begin e_bx = bx; e_by = by; end
      if (k == 4 && upd) begin
        m_x = nx; m_y = ny; m_dx = ndx; m_dy = ndy; m_sp = ns;
        e_bx = 0; e_by = 0;
      end
      check_all($sformatf("eof+%0d", k));
      drive_noise();
      if (k == 4 || in_rst) begin
        drive_quiet();
        if (k == 4 && in_rst) rst_n = 1'b1;
      end else if (k == 2 && rst_updy) begin
        drive_quiet();
        rst_n = 1'b0;
        in_rst = 1;
        upd = 0;
        model_reset();
        #1;
        check_all("rst_updy");
      end else begin
        drive_pulses(pl, pi, pd, 0);
        if (k == 3 && upd) begin
          if (m_inc && !m_dec) ns = (m_sp < 20) ? m_sp + 1 : 20;
          else if (m_dec && !m_inc) ns = (m_sp > 0) ? m_sp - 1 : 0;
          m_inc = inc_vel;
          m_dec = dec_vel;
          m_run = 1;
        end else begin
          absorb();
        end
      end
    end
  endtask

  function automatic bit x_will_bounce();
    int np, nd, nb;
    axis(m_x, m_dx, m_sp, 0, X_MAX, np, nd, nb);
    return nb != 0;
  endfunction

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int iter;
    rst_n = 1'b0;
    RGBStr_i = '0;
    drive_quiet();
    model_reset();
    repeat (2) @(negedge px_clk);
    check_all("reset");
    rst_n = 1'b1;

    // No launch: eofs must be ignored
    repeat (3) frame(0, 0, 0, 0, 0);
    chk("idle.x", 32'(x_logo), 32'd140);
    chk("idle.y", 32'(y_logo), 32'd192);

    // Launch, then three plain frames at speed 1
    frame(100, 0, 0, 0, 0);
    repeat (2) frame(0, 0, 0, 0, 0);
    chk("launch3.x", 32'(x_logo), 32'd143);
    chk("launch3.y", 32'(y_logo), 32'd195);

    // Speed up to saturation, then down to zero, then mixed with pauses
    repeat (40) frame(10, 60, 0, 10, 0);
    chk("sat.hi", 32'(speed), 32'd20);
    repeat (60) frame(10, 0, 60, 10, 0);
    chk("sat.lo", 32'(speed), 32'd0);
    repeat (120) frame(10, 40, 40, 25, 0);

    // Reset while Y is being stepped after an X reflection
    iter = 0;
    while (!(m_run && x_will_bounce()) && iter < 200) begin
      frame(100, 40, 5, 0, 0);
      iter++;
    end
    chk("find_xbounce", 32'(m_run && x_will_bounce()), 32'd1);
    frame(0, 0, 0, 0, 1);
    chk("post_rst.run", 32'(running), 32'd0);

    // Recovery after reset
    repeat (20) frame(30, 30, 20, 15, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
